video_testcard_gen: RTL and testbench

//  Parametrised monochrome composite-video pattern generator, successor to the fixed

---
 rtl/video_testcard_gen_pkg.sv | 26 ++
 rtl/video_testcard_gen_if.sv | 22 ++
 rtl/video_testcard_gen_timing.sv | 72 +++++++
 rtl/video_testcard_gen.sv | 103 ++++++++++
 tb/tb_video_testcard_gen.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/video_testcard_gen_pkg.sv
// Shared definitions for the composite testcard generator: pattern encodings,
// 12 MHz PAL timing defaults and the grey-bar level function.
package video_pkg;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_CHECK = 2'd1,
        MODE_HATCH = 2'd2,
        MODE_FLAT  = 2'd3
    } mode_e;

    localparam int PAL_H_TOTAL  = 768;
    localparam int PAL_H_SYNC   = 56;
    localparam int PAL_H_BACK   = 68;
    localparam int PAL_H_ACTIVE = 624;
    localparam int PAL_V_TOTAL  = 312;
    localparam int PAL_V_SYNC   = 3;
    localparam int PAL_V_START  = 20;
    localparam int PAL_V_ACTIVE = 270;

    // Bar 0 is peak white, bar 7 is black, evenly stepped in between.
    function automatic int bar_level(input int k, input int luma_max);
        return ((7 - k) * luma_max) / 7;
    endfunction

endpackage

// File: rtl/video_testcard_gen_if.sv
// Control inputs and DAC/overlay outputs of the testcard generator.
// master = generator side, slave = board / overlay side.
interface video_testcard_gen_if #(parameter int LUMA_W = 4);
    logic [1:0]        i_mode;
    logic [LUMA_W-1:0] i_level;
    logic              o_sync;
    logic [LUMA_W-1:0] o_luma;
    logic              o_white;
    logic              o_active;
    logic [9:0]        o_hpos;
    logic [8:0]        o_vpos;
    logic              o_frame_start;

    modport master (
        input  i_mode, i_level,
        output o_sync, o_luma, o_white, o_active, o_hpos, o_vpos, o_frame_start
    );
    modport slave (
        output i_mode, i_level,
        input  o_sync, o_luma, o_white, o_active, o_hpos, o_vpos, o_frame_start
    );
endinterface

// File: rtl/video_testcard_gen_timing.sv
// Line/field counters plus sync, active window and active-area position.
// Exposes both the combinational position (for the pattern stage) and registered copies.
module video_timing import video_pkg::*; #(
    parameter int H_TOTAL  = PAL_H_TOTAL,
    parameter int H_SYNC   = PAL_H_SYNC,
    parameter int H_BACK   = PAL_H_BACK,
    parameter int H_ACTIVE = PAL_H_ACTIVE,
    parameter int V_TOTAL  = PAL_V_TOTAL,
    parameter int V_SYNC   = PAL_V_SYNC,
    parameter int V_START  = PAL_V_START,
    parameter int V_ACTIVE = PAL_V_ACTIVE
) (
    input  logic       clk,
    input  logic       rst,
    output logic       o_pix_act,
    output logic [9:0] o_pix_x,
    output logic [8:0] o_pix_y,
    output logic       o_field_start,
    output logic       o_sync,
    output logic       o_active,
    output logic [9:0] o_hpos,
    output logic [8:0] o_vpos,
    output logic       o_frame_start
);
    localparam int HW  = $clog2(H_TOTAL);
    localparam int VW  = $clog2(V_TOTAL);
    localparam int HA0 = H_SYNC + H_BACK;
    localparam int HA1 = HA0 + H_ACTIVE;
    localparam int VA1 = V_START + V_ACTIVE;

    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    logic [31:0]   w_h, w_v;
    logic          w_hact, w_vact, w_sync;

    assign w_h    = 32'(r_hcnt);
    assign w_v    = 32'(r_vcnt);
    assign w_hact = (w_h >= HA0) && (w_h < HA1);
    assign w_vact = (w_v >= V_START) && (w_v < VA1);

    assign o_pix_act     = w_hact && w_vact;
    assign o_pix_x       = o_pix_act ? 10'(w_h - HA0) : '0;
    assign o_pix_y       = o_pix_act ? 9'(w_v - V_START) : '0;
    assign o_field_start = (r_hcnt == '0) && (r_vcnt == '0);

    // Broad-pulse lines invert the duty: long sync tip, short black gap.
    assign w_sync = (w_v < V_SYNC) ? (w_h >= H_TOTAL - H_SYNC) : (w_h >= H_SYNC);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            o_sync        <= 1'b1;
            o_active      <= 1'b0;
            o_hpos        <= '0;
            o_vpos        <= '0;
            o_frame_start <= 1'b0;
        end else begin
            if (w_h == H_TOTAL - 1) begin
                r_hcnt <= '0;
                r_vcnt <= (w_v == V_TOTAL - 1) ? '0 : r_vcnt + 1'b1;
            end else begin
                r_hcnt <= r_hcnt + 1'b1;
            end
            o_sync        <= w_sync;
            o_active      <= o_pix_act;
            o_hpos        <= o_pix_x;
            o_vpos        <= o_pix_y;
            o_frame_start <= o_field_start;
        end
    end
endmodule

// File: rtl/video_testcard_gen.sv
// Monochrome composite testcard: timing core plus field-latched pattern select and luma
// stage. Every output is one register behind the counters.
module video_testcard_gen import video_pkg::*; #(
    parameter int H_TOTAL  = PAL_H_TOTAL,
    parameter int H_SYNC   = PAL_H_SYNC,
    parameter int H_BACK   = PAL_H_BACK,
    parameter int H_ACTIVE = PAL_H_ACTIVE,
    parameter int V_TOTAL  = PAL_V_TOTAL,
    parameter int V_SYNC   = PAL_V_SYNC,
    parameter int V_START  = PAL_V_START,
    parameter int V_ACTIVE = PAL_V_ACTIVE,
    parameter int LUMA_W   = 4,
    parameter int CELL_SH  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    video_testcard_gen_if.master vif
);
    localparam logic [LUMA_W-1:0] LUMA_MAX = '1;
    localparam int                BAR_W    = H_ACTIVE / 8;

    if (H_SYNC + H_BACK + H_ACTIVE > H_TOTAL) begin : g_err_h
        $error("horizontal timing exceeds H_TOTAL");
    end
    if (V_START + V_ACTIVE > V_TOTAL) begin : g_err_v
        $error("vertical timing exceeds V_TOTAL");
    end
    if (V_SYNC >= V_START) begin : g_err_vs
        $error("V_SYNC must end before V_START");
    end
    if (H_ACTIVE > 1024 || V_ACTIVE > 512) begin : g_err_pos
        $error("active area exceeds position output width");
    end

    logic              w_pix_act, w_field_start;
    logic [9:0]        w_x, w_bar;
    logic [8:0]        w_y;
    logic [LUMA_W-1:0] w_lut [8];
    logic [LUMA_W-1:0] w_luma;
    mode_e             r_mode;
    logic [LUMA_W-1:0] r_level, r_luma;
    logic              r_white;

    video_timing #(
        .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACTIVE(H_ACTIVE),
        .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_START(V_START), .V_ACTIVE(V_ACTIVE)
    ) u_timing (
        .clk           (clk),
        .rst           (rst),
        .o_pix_act     (w_pix_act),
        .o_pix_x       (w_x),
        .o_pix_y       (w_y),
        .o_field_start (w_field_start),
        .o_sync        (vif.o_sync),
        .o_active      (vif.o_active),
        .o_hpos        (vif.o_hpos),
        .o_vpos        (vif.o_vpos),
        .o_frame_start (vif.o_frame_start)
    );

    for (genvar k = 0; k < 8; k++) begin : g_lut
        assign w_lut[k] = LUMA_W'(bar_level(k, 2**LUMA_W - 1));
    end

    always_comb begin
        w_bar  = w_x / 10'(BAR_W);
        w_luma = '0;
        if (w_pix_act) begin
            case (r_mode)
                // Last bar soaks up the H_ACTIVE % 8 leftover pixels.
                MODE_BARS:  w_luma = w_lut[(w_bar > 10'd7) ? 3'd7 : w_bar[2:0]];
                MODE_CHECK: w_luma = (w_x[CELL_SH] ^ w_y[CELL_SH]) ? '0 : LUMA_MAX;
                MODE_HATCH: begin
                    if (w_x[CELL_SH-1:0] == '0 || w_y[CELL_SH-1:0] == '0 ||
                        w_x == 10'(H_ACTIVE - 1) || w_y == 9'(V_ACTIVE - 1))
                        w_luma = LUMA_MAX;
                end
                MODE_FLAT:  w_luma = r_level;
                default:    w_luma = '0;
            endcase
        end
    end

    // Pattern controls only change on the field boundary so a frame is never torn.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode  <= MODE_BARS;
            r_level <= '0;
            r_luma  <= '0;
            r_white <= 1'b0;
        end else begin
            if (w_field_start) begin
                r_mode  <= mode_e'(vif.i_mode);
                r_level <= vif.i_level;
            end
            r_luma  <= w_luma;
            r_white <= w_pix_act && (w_luma == LUMA_MAX);
        end
    end

    assign vif.o_luma  = r_luma;
    assign vif.o_white = r_white;
endmodule

// File: tb/tb_video_testcard_gen.sv
// Scoreboard bench: stimulus queues (epoch, cycle, signal, value) expectations; a negedge
// monitor pops and compares them. Vertical timing is shortened to keep fields short.
module tb_video_testcard_gen;
    localparam int L = 768;
    localparam int K_SYNC = 0, K_LUMA = 1, K_ACT = 2, K_FS = 3, K_WHITE = 4, K_HPOS = 5, K_VPOS = 6;

    typedef struct {
        int ep;
        int t;
        int k;
        int v;
    } exp_t;

    logic clk, rst;
    int   n;
    int   ep;
    int   n_chk, n_fail;
    exp_t q[$];

    video_testcard_gen_if #(.LUMA_W(4)) vif();

    video_testcard_gen #(
        .V_TOTAL(37), .V_SYNC(3), .V_START(4), .V_ACTIVE(33)
    ) dut (
        .clk (clk),
        .rst (rst),
        .vif (vif.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Posedges since reset release; outputs at negedge after edge n show counter n-1.
    always @(posedge clk or negedge rst) begin
        if (!rst) n <= 0;
        else      n <= n + 1;
    end

    function automatic string kname(input int k);
        case (k)
            K_SYNC:  return "o_sync";
            K_LUMA:  return "o_luma";
            K_ACT:   return "o_active";
            K_FS:    return "o_frame_start";
            K_WHITE: return "o_white";
            K_HPOS:  return "o_hpos";
            default: return "o_vpos";
        endcase
    endfunction

    function automatic int act(input int k);
        case (k)
            K_SYNC:  return int'(vif.o_sync);
            K_LUMA:  return int'(vif.o_luma);
            K_ACT:   return int'(vif.o_active);
            K_FS:    return int'(vif.o_frame_start);
            K_WHITE: return int'(vif.o_white);
            K_HPOS:  return int'(vif.o_hpos);
            default: return int'(vif.o_vpos);
        endcase
    endfunction

    function automatic void chk(input string nm, input int a, input int e);
        n_chk++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endfunction

    function automatic void push(input int ln, input int h, input int k, input int v);
        q.push_back('{ep, ln * L + h, k, v});
    endfunction

    // Monitor
    initial begin
        exp_t e;
        int   t;
        forever begin
            @(negedge clk);
            if (rst) begin
                t = n - 1;
                while (q.size() > 0 && (q[0].ep < ep || (q[0].ep == ep && q[0].t < t))) begin
                    e = q.pop_front();
                    n_chk++;
                    n_fail++;
                    $display("FAIL missed %s ep%0d line %0d h %0d: never sampled, expected %0d",
                             kname(e.k), e.ep, e.t / L, e.t % L, e.v);
                end
                while (q.size() > 0 && q[0].ep == ep && q[0].t == t) begin
                    e = q.pop_front();
                    chk($sformatf("%s ep%0d line %0d h %0d", kname(e.k), e.ep, e.t / L, e.t % L),
                        act(e.k), e.v);
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, " o_sync"}, int'(vif.o_sync), 1);
        chk({tag, " o_luma"}, int'(vif.o_luma), 0);
        chk({tag, " o_white"}, int'(vif.o_white), 0);
        chk({tag, " o_active"}, int'(vif.o_active), 0);
        chk({tag, " o_hpos"}, int'(vif.o_hpos), 0);
        chk({tag, " o_vpos"}, int'(vif.o_vpos), 0);
        chk({tag, " o_frame_start"}, int'(vif.o_frame_start), 0);
    endtask

    task automatic wait_n(input int target);
        int g = 0;
        while (n < target && g < 50000) begin
            @(posedge clk);
            g++;
        end
        chk("wait bound", int'(n >= target), 1);
    endtask

    task automatic drain();
        int g = 0;
        while (q.size() > 0 && g < 40000) begin
            @(negedge clk);
            g++;
        end
        chk("queue drained", q.size(), 0);
    endtask

    // 1 ns reset pulse between clock edges; new mode is latched on the first edge after.
    task automatic do_reset(input logic [1:0] m);
        @(negedge clk);
        #2 rst = 1'b0;
        ep++;
        vif.i_mode = m;
        #1 check_reset_vals("mid-line reset");
        rst = 1'b1;
    endtask

    initial begin
        int bars[8] = '{15, 12, 10, 8, 6, 4, 2, 0};
        n_chk = 0;
        n_fail = 0;
        ep = 0;
        rst = 1'b0;
        vif.i_mode = 2'd0;
        vif.i_level = 4'd0;
        repeat (3) @(posedge clk);
        #1 check_reset_vals("reset");

        // Field 0: grey bars, broad lines, window edges
        push(0, 0, K_FS, 1);    push(0, 0, K_SYNC, 0);  push(0, 0, K_ACT, 0); push(0, 0, K_LUMA, 0);
        push(0, 1, K_FS, 0);    push(0, 711, K_SYNC, 0); push(0, 712, K_SYNC, 1); push(0, 767, K_SYNC, 1);
        push(1, 0, K_SYNC, 0);  push(1, 0, K_FS, 0);
        push(2, 711, K_SYNC, 0); push(2, 712, K_SYNC, 1);
        push(3, 0, K_SYNC, 0);  push(3, 55, K_SYNC, 0); push(3, 56, K_SYNC, 1); push(3, 124, K_ACT, 0);
        push(4, 123, K_ACT, 0); push(4, 124, K_ACT, 1); push(4, 124, K_HPOS, 0); push(4, 124, K_VPOS, 0);
        for (int k = 0; k < 8; k++) begin
            push(4, 124 + 78 * k, K_LUMA, bars[k]);
            push(4, 124 + 78 * k, K_WHITE, (k == 0) ? 1 : 0);
            push(4, 124 + 78 * k + 77, K_LUMA, bars[k]);
        end
        push(4, 747, K_HPOS, 623); push(4, 747, K_ACT, 1);
        push(4, 748, K_ACT, 0);    push(4, 748, K_LUMA, 0); push(4, 748, K_HPOS, 0);
        push(20, 124, K_VPOS, 16); push(20, 124, K_LUMA, 15); push(20, 358, K_LUMA, 8);
        // mode changes at line 22; bars must persist to the end of the field
        push(30, 124, K_LUMA, 15); push(30, 358, K_LUMA, 8);
        push(36, 500, K_VPOS, 32); push(36, 500, K_ACT, 1); push(36, 500, K_LUMA, 6);
        push(36, 767, K_FS, 0);    push(37, 0, K_FS, 1);    push(37, 0, K_SYNC, 0);
        // Field 1: flat level 9
        push(41, 50, K_LUMA, 0);   push(41, 124, K_LUMA, 9); push(41, 124, K_WHITE, 0);
        push(41, 400, K_LUMA, 9);  push(41, 747, K_LUMA, 9); push(41, 748, K_LUMA, 0);

        @(negedge clk);
        rst = 1'b1;
        wait_n(22 * L + 10);
        @(negedge clk);
        vif.i_mode = 2'd3;
        vif.i_level = 4'd9;
        drain();

        // Checkerboard after a mid-line reset
        wait_n(42 * L + 300);
        do_reset(2'd1);
        push(0, 0, K_FS, 1);      push(0, 0, K_SYNC, 0);   push(0, 712, K_SYNC, 1);
        push(3, 56, K_SYNC, 1);
        push(4, 124, K_LUMA, 15); push(4, 155, K_LUMA, 15); push(4, 156, K_LUMA, 0); push(4, 188, K_LUMA, 15);
        push(5, 124, K_VPOS, 1);  push(5, 124, K_LUMA, 15);
        push(36, 124, K_LUMA, 0); push(36, 156, K_LUMA, 15); push(36, 156, K_WHITE, 1);
        drain();

        // Crosshatch
        wait_n(36 * L + 400);
        do_reset(2'd2);
        push(0, 0, K_FS, 1);
        push(4, 129, K_LUMA, 15);
        push(9, 124, K_LUMA, 15); push(9, 129, K_LUMA, 0);   push(9, 129, K_WHITE, 0);
        push(9, 156, K_LUMA, 15); push(9, 157, K_LUMA, 0);
        push(9, 746, K_LUMA, 0);  push(9, 747, K_LUMA, 15);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
